// File: rtl/pad_pkg.sv
// Shared types and constants for the DualShock pad poll sequencer.
package pad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAttSetup,
    StShift,
    StAckWait,
    StGap,
    StFinish
  } pad_state_e;

  localparam logic [7:0] PAD_CMD_START  = 8'h01;
  localparam logic [7:0] PAD_CMD_POLL   = 8'h42;
  localparam logic [7:0] PAD_RESP_READY = 8'h5A;
  localparam int unsigned PAD_FRAME_BYTES = 5;

  // Command byte sent in frame slot idx; slots 2..4 are padding.
  function automatic logic [7:0] pad_cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return PAD_CMD_START;
      3'd1:    return PAD_CMD_POLL;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int unsigned pad_max3(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pad_poll_sequencer_if.sv
// Request/status bundle between the system-side poller and pad_poll_sequencer.
interface pad_poll_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] buttons;
  logic [7:0]  pad_id;

  modport master (output start, input busy, input done, input error, input buttons,
                  input pad_id);
  modport slave  (input start, output busy, output done, output error, output buttons,
                  output pad_id);
endinterface

// File: rtl/pad_bit_timer.sv
// Pad-clock half-period timer: rise_tick ends the low half, fall_tick ends the high half.
module pad_bit_timer #(
  parameter int unsigned HALF_CYC = 50
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic en,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int unsigned CntW = $clog2(HALF_CYC + 1);

  logic [CntW-1:0] cnt_q;
  logic            high_q;
  logic            wrap;

  assign wrap      = en && (cnt_q == CntW'(HALF_CYC - 1));
  assign rise_tick = wrap && !high_q;
  assign fall_tick = wrap && high_q;

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n || !en) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      high_q <= ~high_q;
    end else begin
      cnt_q  <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/pad_poll_sequencer.sv
// DualShock poll-frame sequencer: five LSB-first full-duplex bytes, returns a button word.
// Define PAD_AUTO_POLL_EN to add an internal poll request every POLL_PERIOD_CYC cycles.
module pad_poll_sequencer
  import pad_pkg::*;
#(
  parameter int unsigned HALF_CYC        = 50,
  parameter int unsigned ATT_SETUP_CYC   = 800,
  parameter int unsigned ACK_TIMEOUT_CYC = 500,
  parameter int unsigned GAP_CYC         = 100,
  parameter int unsigned POLL_PERIOD_CYC = 833333
) (
  input  logic                  clk_50mhz,
  input  logic                  rst_n,
  pad_poll_sequencer_if.slave   req,
  output logic                  pad_att_n,
  output logic                  pad_clk,
  output logic                  pad_cmd,
  input  logic                  pad_dat,
  input  logic                  pad_ack_n
);

  localparam int unsigned CntMax = pad_max3(ATT_SETUP_CYC, ACK_TIMEOUT_CYC, GAP_CYC);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  pad_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      id_q, id_d;
  logic [7:0]      b3_q, b3_d;
  logic [7:0]      b4_q, b4_d;
  logic            err_q, err_d;
  logic            att_q, att_d;
  logic            pclk_q, pclk_d;
  logic            cmd_q, cmd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [15:0]     buttons_q, buttons_d;
  logic [7:0]      pad_id_q, pad_id_d;

  logic [1:0]      dat_sync_q;
  logic [1:0]      ack_sync_q;
  logic            dat_s;
  logic            ack_s;
  logic [7:0]      cur_cmd;
  logic            fall_tick;
  logic            rise_tick;
  logic            start_req;

  assign dat_s   = dat_sync_q[1];
  assign ack_s   = ack_sync_q[1];
  assign cur_cmd = pad_cmd_byte(byte_q);

  pad_bit_timer #(
    .HALF_CYC (HALF_CYC)
  ) u_bit_timer (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .en        (state_q == StShift),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

`ifdef PAD_AUTO_POLL_EN
  localparam int unsigned PollW = $clog2(POLL_PERIOD_CYC + 1);

  logic [PollW-1:0] poll_cnt_q;
  logic             poll_tick;

  assign poll_tick = (poll_cnt_q == PollW'(POLL_PERIOD_CYC - 1));
  assign start_req = req.start | poll_tick;

  // Period is measured from the last accepted start; a tick landing mid-frame is dropped.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n || poll_tick || (state_q == StIdle && start_req)) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_q + PollW'(1);
    end
  end
`else
  logic unused_poll_period;
  assign unused_poll_period = (POLL_PERIOD_CYC != 0);
  assign start_req          = req.start;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_d     = bit_q;
    byte_d    = byte_q;
    rx_d      = rx_q;
    id_d      = id_q;
    b3_d      = b3_q;
    b4_d      = b4_q;
    err_d     = err_q;
    att_d     = att_q;
    pclk_d    = pclk_q;
    cmd_d     = cmd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    buttons_d = buttons_q;
    pad_id_d  = pad_id_q;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_req) begin
          state_d = StAttSetup;
          att_d   = 1'b0;
          busy_d  = 1'b1;
          error_d = 1'b0;
          err_d   = 1'b0;
          byte_d  = '0;
          bit_d   = '0;
        end
      end

      StAttSetup: begin
        if (cnt_q == CntW'(ATT_SETUP_CYC - 1)) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          pclk_d  = 1'b0;
          cmd_d   = PAD_CMD_START[0];
        end
      end

      StShift: begin
        cnt_d = '0;
        if (rise_tick) begin
          pclk_d = 1'b1;
          rx_d   = {dat_s, rx_q[7:1]};
        end else if (fall_tick) begin
          if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            pclk_d = 1'b0;
            cmd_d  = cur_cmd[bit_q + 3'd1];
          end else begin
            bit_d = '0;
            cmd_d = 1'b1;
            case (byte_q)
              3'd1:    id_d = rx_q;
              3'd2:    if (rx_q != PAD_RESP_READY) err_d = 1'b1;
              3'd3:    b3_d = rx_q;
              3'd4:    b4_d = rx_q;
              default: ;
            endcase
            if (byte_q == 3'(PAD_FRAME_BYTES - 1)) begin
              state_d = StFinish;
            end else begin
              state_d = StAckWait;
              byte_d  = byte_q + 3'd1;
            end
          end
        end
      end

      StAckWait: begin
        if (!ack_s) begin
          state_d = StGap;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(ACK_TIMEOUT_CYC - 1)) begin
          state_d = StFinish;
          err_d   = 1'b1;
        end
      end

      StGap: begin
        if (cnt_q == CntW'(GAP_CYC - 1)) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
          pclk_d  = 1'b0;
          cmd_d   = cur_cmd[0];
        end
      end

      StFinish: begin
        state_d = StIdle;
        cnt_d   = '0;
        att_d   = 1'b1;
        pclk_d  = 1'b1;
        cmd_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (err_q) begin
          error_d = 1'b1;
        end else begin
          buttons_d = ~{b4_q, b3_q};
          pad_id_d  = id_q;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      rx_q       <= '0;
      id_q       <= '0;
      b3_q       <= '0;
      b4_q       <= '0;
      err_q      <= 1'b0;
      att_q      <= 1'b1;
      pclk_q     <= 1'b1;
      cmd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      buttons_q  <= '0;
      pad_id_q   <= '0;
      dat_sync_q <= 2'b11;
      ack_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      rx_q       <= rx_d;
      id_q       <= id_d;
      b3_q       <= b3_d;
      b4_q       <= b4_d;
      err_q      <= err_d;
      att_q      <= att_d;
      pclk_q     <= pclk_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      buttons_q  <= buttons_d;
      pad_id_q   <= pad_id_d;
      dat_sync_q <= {dat_sync_q[0], pad_dat};
      ack_sync_q <= {ack_sync_q[0], pad_ack_n};
    end
  end

  assign pad_att_n   = att_q;
  assign pad_clk     = pclk_q;
  assign pad_cmd     = cmd_q;
  assign req.busy    = busy_q;
  assign req.done    = done_q;
  assign req.error   = error_q;
  assign req.buttons = buttons_q;
  assign req.pad_id  = pad_id_q;

endmodule

// File: tb/tb_pad_poll_sequencer.sv
// Scoreboard bench for pad_poll_sequencer with a behavioural DualShock pad model.
module tb_pad_poll_sequencer;

  localparam int ACK_DLY = 200;
  localparam int ACK_W   = 50;

  typedef struct packed {
    logic        err;
    logic [15:0] btn;
    logic [7:0]  id;
  } exp_t;

  logic clk_50mhz = 1'b0;
  logic rst_n     = 1'b0;
  logic pad_att_n;
  logic pad_clk;
  logic pad_cmd;
  logic pad_dat   = 1'b1;
  logic pad_ack_n = 1'b1;

  pad_poll_sequencer_if bus ();

  pad_poll_sequencer dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .req       (bus),
    .pad_att_n (pad_att_n),
    .pad_clk   (pad_clk),
    .pad_cmd   (pad_cmd),
    .pad_dat   (pad_dat),
    .pad_ack_n (pad_ack_n)
  );

  initial forever #10 clk_50mhz = ~clk_50mhz;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Pad model: presents data on falling pad_clk, captures pad_cmd on rising pad_clk.
  logic [7:0]  resp [5];
  logic [3:0]  ack_en = 4'hF;
  logic [39:0] cmd_obs = '0;
  logic        prev_clk = 1'b1;
  logic        prev_att = 1'b1;
  int cyc = 0, m_bit = 0, m_byte = 0, rises = 0, period_bad = 0, att_falls = 0;
  int last_rise = 0, last_fall = 0, ack_at = -1, done_count = 0;

  always @(posedge clk_50mhz) cyc <= cyc + 1;

  always @(negedge clk_50mhz) begin
    if (prev_att && !pad_att_n) att_falls++;
    if (pad_att_n) begin
      m_bit  = 0;
      m_byte = 0;
    end else if (m_byte < 5) begin
      if (prev_clk && !pad_clk) begin
        pad_dat   = resp[m_byte][m_bit];
        last_fall = cyc;
      end
      if (!prev_clk && pad_clk) begin
        rises++;
        cmd_obs[m_byte*8 + m_bit] = pad_cmd;
        if (cyc - last_fall != 50) period_bad++;
        if (m_bit != 0 && cyc - last_rise != 100) period_bad++;
        last_rise = cyc;
        if (m_bit == 7) begin
          if (m_byte < 4 && ack_en[m_byte]) ack_at = cyc + ACK_DLY;
          m_bit = 0;
          m_byte++;
        end else begin
          m_bit++;
        end
      end
    end
    if (cyc == ack_at) pad_ack_n = 1'b0;
    else if (ack_at >= 0 && cyc == ack_at + ACK_W) begin
      pad_ack_n = 1'b1;
      ack_at    = -1;
    end
    prev_clk = pad_clk;
    prev_att = pad_att_n;
  end

  // Monitor: every done pulse pops one expected frame result.
  always @(negedge clk_50mhz) begin
    if (rst_n && bus.done) begin
      exp_t e;
      done_count++;
      check("done_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("frame_error", bus.error, e.err);
        check("frame_buttons", bus.buttons, e.btn);
        check("frame_pad_id", bus.pad_id, e.id);
        check("att_released_at_done", pad_att_n, 1);
      end
    end
  end

  task automatic set_resp(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                          input logic [7:0] r3, input logic [7:0] r4);
    resp[0] = r0; resp[1] = r1; resp[2] = r2; resp[3] = r3; resp[4] = r4;
  endtask

  task automatic start_pulse();
    @(negedge clk_50mhz);
    bus.start = 1'b1;
    @(negedge clk_50mhz);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("att_low_after_start", pad_att_n, 0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk_50mhz);
      n++;
    end
    check("done_within_budget", bus.done, 1);
  endtask

  int r0, pb0, af0, dc0;

  initial begin
    bus.start = 1'b0;
    set_resp(8'hFF, 8'h41, 8'h5A, 8'h7F, 8'hFE);
    repeat (3) @(negedge clk_50mhz);
    check("reset_pins", {pad_att_n, pad_clk, pad_cmd}, 3'b111);
    check("reset_status", {bus.busy, bus.done, bus.error}, 3'b000);
    check("reset_buttons", bus.buttons, 16'h0000);
    check("reset_pad_id", bus.pad_id, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50mhz);

    // Nominal frame: command bytes, clock shape, done latency.
    r0 = rises; pb0 = period_bad;
    exp_q.push_back({1'b0, 16'h0180, 8'h41});
    start_pulse();
    wait_done(10000);
    check("done_after_last_rise", cyc - last_rise, 51);
    check("cmd_bytes", cmd_obs, 40'h00_00_00_42_01);
    check("pad_clk_period_duty", period_bad - pb0, 0);
    check("rises_nominal", rises - r0, 40);
    repeat (5) @(negedge clk_50mhz);

    // Different button pattern.
    set_resp(8'hFF, 8'h73, 8'h5A, 8'h00, 8'hFF);
    exp_q.push_back({1'b0, 16'h00FF, 8'h73});
    start_pulse();
    wait_done(10000);
    repeat (5) @(negedge clk_50mhz);

    // ACK withheld after byte 1: timeout, outputs kept.
    set_resp(8'hFF, 8'h41, 8'h5A, 8'h7F, 8'hFE);
    ack_en = 4'b1101;
    r0 = rises;
    exp_q.push_back({1'b1, 16'h00FF, 8'h73});
    start_pulse();
    wait_done(10000);
    check("timeout_latency", cyc - last_rise, 551);
    check("rises_timeout", rises - r0, 16);
    repeat (20) @(negedge clk_50mhz);
    check("error_held", {bus.error, bus.busy}, 2'b10);
    ack_en = 4'hF;

    // Bad ready byte: full frame clocked, error, pad_id/buttons unchanged.
    set_resp(8'hFF, 8'h12, 8'h00, 8'hAA, 8'h55);
    r0 = rises;
    exp_q.push_back({1'b1, 16'h00FF, 8'h73});
    start_pulse();
    check("error_cleared_on_start", bus.error, 0);
    wait_done(10000);
    check("rises_bad_ready", rises - r0, 40);
    repeat (5) @(negedge clk_50mhz);

    // start held high: one frame per IDLE visit.
    set_resp(8'hFF, 8'h41, 8'h5A, 8'h7F, 8'hFE);
    af0 = att_falls; dc0 = done_count;
    exp_q.push_back({1'b0, 16'h0180, 8'h41});
    @(negedge clk_50mhz);
    bus.start = 1'b1;
    wait_done(10000);
    check("held_start_one_frame", att_falls - af0, 1);
    check("busy_low_at_done", bus.busy, 0);
    @(negedge clk_50mhz);
    check("restart_after_idle", bus.busy, 1);
    bus.start = 1'b0;
    exp_q.push_back({1'b0, 16'h0180, 8'h41});
    wait_done(10000);
    repeat (5) @(negedge clk_50mhz);
    check("held_start_done_count", done_count - dc0, 2);

    // Reset during byte 2.
    dc0 = done_count;
    start_pulse();
    begin
      int n;
      n = 0;
      while (m_byte != 2 && n < 10000) begin
        @(negedge clk_50mhz);
        n++;
      end
      check("reached_byte2", m_byte, 2);
    end
    repeat (120) @(negedge clk_50mhz);
    rst_n = 1'b0;
    @(negedge clk_50mhz);
    check("midreset_pins", {pad_att_n, pad_clk, pad_cmd}, 3'b111);
    check("midreset_status", {bus.busy, bus.done, bus.error}, 3'b000);
    check("midreset_outputs", {bus.buttons, bus.pad_id}, 24'h0);
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk_50mhz);
    check("no_done_after_reset", done_count - dc0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
